// File: rtl/feature_match_ctrl_pkg.sv
// Shared encodings for the feature comparator sequencer and its accumulator array.
package feature_match_pkg;
  localparam int WORD_W = 16;
  localparam int DIFF_W = 4;

  localparam logic [1:0] CMP_IDLE = 2'b00;
  localparam logic [1:0] CMP_RUN  = 2'b01;
  localparam logic [1:0] CMP_CLR  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DRAIN,
    ST_SCAN,
    ST_DONE
  } fsm_e;

  // Index width that never collapses to zero for single-entry ranges.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/diff_accum_array.sv
// Per-template diff accumulators: one lane per comparator, common clear/enable,
// single indexed read port used by the serial argmin scan.
module diff_accum_lane
  import feature_match_pkg::*;
#(
  parameter int ACC_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic [DIFF_W-1:0] diff,
  output logic [ACC_W-1:0]  acc
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      acc <= '0;
    else if (clr) acc <= '0;
    else if (en)  acc <= acc + ACC_W'(diff);
  end
endmodule

module diff_accum_array
  import feature_match_pkg::*;
#(
  parameter int MODN  = 30,
  parameter int ACC_W = 10,
  parameter int IDX_W = 5
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clr,
  input  logic                         en,
  input  logic [MODN-1:0][DIFF_W-1:0]  diff,
  input  logic [IDX_W-1:0]             rd_idx,
  output logic [ACC_W-1:0]             rd_data
);
  logic [MODN-1:0][ACC_W-1:0] acc;

  for (genvar i = 0; i < MODN; i++) begin : g_lane
    diff_accum_lane #(.ACC_W(ACC_W)) u_lane (
      .clk  (clk),
      .rst  (rst),
      .clr  (clr),
      .en   (en),
      .diff (diff[i]),
      .acc  (acc[i])
    );
  end

  assign rd_data = acc[rd_idx];
endmodule

// File: rtl/feature_match_ctrl.sv
// Frame sequencer for the comparator array: streams feature words, accumulates
// per-template diffs behind a tag pipe, then scans serially for the best template.
module feature_match_ctrl
  import feature_match_pkg::*;
#(
  parameter int MODN    = 30,
  parameter int NWORDS  = 64,
  parameter int CMP_LAT = 2,
  localparam int ACC_W  = $clog2(NWORDS*15+1),
  localparam int IDX_W  = idx_w(MODN)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  input  logic [ACC_W-1:0]       thresh,
  input  logic                   in_valid,
  input  logic [WORD_W-1:0]      in_data,
  output logic                   in_ready,
  output logic [1:0]             cmp_state,
  output logic [WORD_W-1:0]      cmp_data,
  input  logic [MODN*DIFF_W-1:0] cmp_diff_bus,
  output logic                   busy,
  output logic                   done,
  output logic [IDX_W-1:0]       best_idx,
  output logic [ACC_W-1:0]       best_score,
  output logic                   match
);
  localparam int CNT_W = idx_w(NWORDS);

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic [ACC_W-1:0] score;
    logic             match;
  } res_t;

  fsm_e                        state, state_nxt;
  logic [CNT_W-1:0]            word_cnt;
  logic [CMP_LAT-1:0]          vld_pipe, vld_nxt;
  logic [ACC_W-1:0]            thresh_q, rd_data, run_score, fin_score;
  logic [IDX_W-1:0]            scan_idx, run_idx, fin_idx;
  logic [MODN-1:0][DIFF_W-1:0] diff_lanes;
  res_t                        res_q;
  logic                        xfer, accept, last_word, last_lane, take;

  assign diff_lanes = cmp_diff_bus;
  assign xfer       = in_valid & in_ready;
  assign accept     = (state == ST_IDLE) & start & ~abort;
  assign last_word  = (word_cnt == CNT_W'(NWORDS-1));
  assign last_lane  = (scan_idx == IDX_W'(MODN-1));
  // Each accepted word tags the cycle its diffs will land on the bus.
  assign vld_nxt    = CMP_LAT'({vld_pipe, xfer});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (abort) state_nxt = ST_IDLE;
    else begin
      case (state)
        ST_IDLE:  if (start) state_nxt = ST_LOAD;
        ST_LOAD:  if (xfer && last_word) state_nxt = ST_DRAIN;
        // Leave once the final tag is at the pipe output this cycle.
        ST_DRAIN: if (vld_nxt == '0) state_nxt = ST_SCAN;
        ST_SCAN:  if (last_lane) state_nxt = ST_DONE;
        ST_DONE:  state_nxt = ST_IDLE;
        default:  state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    in_ready  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    cmp_state = CMP_IDLE;
    case (state)
      ST_LOAD:  begin in_ready = 1'b1; busy = 1'b1; cmp_state = CMP_RUN; end
      ST_DRAIN: begin busy = 1'b1; cmp_state = CMP_RUN; end
      ST_SCAN:  begin busy = 1'b1; cmp_state = CMP_CLR; end
      ST_DONE:  done = 1'b1;
      default:  ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
      word_cnt <= '0;
      thresh_q <= '0;
      cmp_data <= '0;
    end else begin
      vld_pipe <= abort ? '0 : vld_nxt;
      if (accept)    begin word_cnt <= '0; thresh_q <= thresh; end
      else if (xfer) word_cnt <= word_cnt + 1'b1;
      if (xfer) cmp_data <= in_data;
    end
  end

  diff_accum_array #(.MODN(MODN), .ACC_W(ACC_W), .IDX_W(IDX_W)) u_acc (
    .clk     (clk),
    .rst     (rst),
    .clr     (accept),
    .en      (vld_pipe[CMP_LAT-1]),
    .diff    (diff_lanes),
    .rd_idx  (scan_idx),
    .rd_data (rd_data)
  );

  // Strict less-than keeps the lowest index on ties.
  assign take      = (scan_idx == '0) || (rd_data < run_score);
  assign fin_idx   = take ? scan_idx : run_idx;
  assign fin_score = take ? rd_data  : run_score;

  // Running minimum is private so an aborted scan never disturbs reported results.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_idx  <= '0;
      run_idx   <= '0;
      run_score <= '0;
      res_q     <= '0;
    end else begin
      scan_idx <= (state == ST_SCAN) ? scan_idx + 1'b1 : '0;
      if (state == ST_SCAN) begin
        run_idx   <= fin_idx;
        run_score <= fin_score;
      end
      if (state == ST_SCAN && last_lane && !abort) begin
        res_q.idx   <= fin_idx;
        res_q.score <= fin_score;
        res_q.match <= (fin_score <= thresh_q);
      end
    end
  end

  assign best_idx   = res_q.idx;
  assign best_score = res_q.score;
  assign match      = res_q.match;
endmodule

// File: tb/tb_feature_match_ctrl.sv
// Scoreboard bench: a small 4-lane instance for directed frames and a 30-lane
// instance for the full-size saturation-free scoring case.
module tb_feature_match_ctrl;
  localparam int MODN    = 4;
  localparam int NWORDS  = 4;
  localparam int CMP_LAT = 2;
  localparam int S_ACC   = $clog2(NWORDS*15+1);
  localparam int S_IDX   = 2;
  localparam int BM      = 30;
  localparam int BN      = 64;
  localparam int B_ACC   = $clog2(BN*15+1);
  localparam int B_IDX   = 5;

  typedef struct {int idx; int score; int m;} exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic             start, abort, in_valid, in_ready, busy, done, match;
  logic [S_ACC-1:0] thresh, best_score;
  logic [15:0]      in_data, cmp_data, dq;
  logic [1:0]       cmp_state;
  logic [MODN*4-1:0] cmp_diff_bus;
  logic [S_IDX-1:0] best_idx;

  logic             b_start, b_abort, b_in_valid, b_in_ready, b_busy, b_done, b_match;
  logic [B_ACC-1:0] b_thresh, b_best_score;
  logic [15:0]      b_in_data, b_cmp_data, b_dq;
  logic [1:0]       b_cmp_state;
  logic [BM*4-1:0]  b_diff;
  logic [B_IDX-1:0] b_best_idx;

  feature_match_ctrl #(.MODN(MODN), .NWORDS(NWORDS), .CMP_LAT(CMP_LAT)) u_dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .thresh(thresh),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .cmp_state(cmp_state), .cmp_data(cmp_data), .cmp_diff_bus(cmp_diff_bus),
    .busy(busy), .done(done), .best_idx(best_idx), .best_score(best_score), .match(match)
  );

  feature_match_ctrl #(.MODN(BM), .NWORDS(BN), .CMP_LAT(CMP_LAT)) u_big (
    .clk(clk), .rst(rst), .start(b_start), .abort(b_abort), .thresh(b_thresh),
    .in_valid(b_in_valid), .in_data(b_in_data), .in_ready(b_in_ready),
    .cmp_state(b_cmp_state), .cmp_data(b_cmp_data), .cmp_diff_bus(b_diff),
    .busy(b_busy), .done(b_done), .best_idx(b_best_idx), .best_score(b_best_score), .match(b_match)
  );

  // Array model: lane i diff is nibble (i%4) of the word; the array register adds
  // one cycle on top of the cmp_data register, giving CMP_LAT from acceptance.
  always @(posedge clk or posedge rst) begin
    if (rst) begin dq <= '0; b_dq <= '0; end
    else     begin dq <= cmp_data; b_dq <= b_cmp_data; end
  end
  assign cmp_diff_bus = dq;
  always_comb begin
    b_diff = '0;
    for (int i = 0; i < BM; i++) b_diff[i*4 +: 4] = b_dq[(i%4)*4 +: 4];
  end

  int   checks = 0, failures = 0, cyc = 0, s_last = 0, b_last = 0;
  exp_t s_q[$], b_q[$];
  exp_t s_e, b_e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (in_valid && in_ready) s_last = cyc;
      if (done) begin
        if (s_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL s_done: unexpected done pulse, got idx=%0d score=%0d, expected no done",
                   best_idx, best_score);
        end else begin
          s_e = s_q.pop_front();
          chk("s_best_idx",   int'(best_idx),   s_e.idx);
          chk("s_best_score", int'(best_score), s_e.score);
          chk("s_match",      int'(match),      s_e.m);
          chk("s_latency",    cyc - s_last,     CMP_LAT + MODN + 1);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (b_in_valid && b_in_ready) b_last = cyc;
      if (b_done) begin
        if (b_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL b_done: unexpected done pulse, got score=%0d, expected no done", b_best_score);
        end else begin
          b_e = b_q.pop_front();
          chk("b_best_idx",   int'(b_best_idx),   b_e.idx);
          chk("b_best_score", int'(b_best_score), b_e.score);
          chk("b_match",      int'(b_match),      b_e.m);
          chk("b_latency",    cyc - b_last,       CMP_LAT + BM + 1);
        end
      end
    end
  end

  task automatic sync();
    @(posedge clk); #1;
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_in_ready"},   int'(in_ready),   0);
    chk({nm, "_busy"},       int'(busy),       0);
    chk({nm, "_done"},       int'(done),       0);
    chk({nm, "_cmp_state"},  int'(cmp_state),  0);
    chk({nm, "_cmp_data"},   int'(cmp_data),   0);
    chk({nm, "_best_idx"},   int'(best_idx),   0);
    chk({nm, "_best_score"}, int'(best_score), 0);
    chk({nm, "_match"},      int'(match),      0);
  endtask

  task automatic do_start(input int th);
    start = 1'b1; thresh = S_ACC'(th);
    sync();
    start = 1'b0;
  endtask

  task automatic send(input logic [15:0] w);
    int got = 0;
    in_valid = 1'b1; in_data = w;
    for (int n = 0; n < 50 && got == 0; n++) begin
      @(negedge clk);
      if (in_ready) got = 1;
      sync();
    end
    in_valid = 1'b0;
    if (got == 0) chk("send_ready_timeout", got, 1);
  endtask

  task automatic wait_frames(input string nm);
    int n = 0;
    while ((s_q.size() != 0 || b_q.size() != 0) && n < 400) begin
      @(posedge clk); n++;
    end
    chk({nm, "_pending"}, s_q.size() + b_q.size(), 0);
    sync();
  endtask

  bit pat [7] = '{1, 0, 0, 1, 1, 0, 1};

  initial begin
    rst = 1'b0; start = 1'b0; abort = 1'b0; in_valid = 1'b0; in_data = '0; thresh = '0;
    b_start = 1'b0; b_abort = 1'b0; b_in_valid = 1'b0; b_in_data = '0; b_thresh = '0;
    #2 rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_zero("reset");
    chk("reset_b_busy", int'(b_busy), 0);
    rst = 1'b0;
    sync();

    // 1: lane totals 4,8,12,16
    s_q.push_back(exp_t'{0, 4, 1});
    do_start(8);
    @(negedge clk);
    chk("t1_load_ready", int'(in_ready), 1);
    chk("t1_load_cmp",   int'(cmp_state), 1);
    sync();
    for (int k = 0; k < 4; k++) send(16'h4321);
    wait_frames("t1");

    // 2: tie between lanes 1 and 3
    s_q.push_back(exp_t'{1, 2, 0});
    do_start(1);
    send(16'h0313); send(16'h0313); send(16'h1202); send(16'h1202);
    wait_frames("t2");

    // 3: bubbles carry FFFF but must not be accumulated
    s_q.push_back(exp_t'{0, 4, 0});
    do_start(3);
    for (int k = 0; k < 7; k++) begin
      in_valid = pat[k];
      in_data  = pat[k] ? 16'h1111 : 16'hFFFF;
      sync();
    end
    in_valid = 1'b0;
    wait_frames("t3");

    // 4: stray starts in LOAD and SCAN; totals 32,28,24,20, score equals thresh
    s_q.push_back(exp_t'{3, 20, 1});
    do_start(20);
    send(16'h5678);
    start = 1'b1; sync(); start = 1'b0;
    @(negedge clk);
    chk("t4_load_cmp", int'(cmp_state), 1);
    sync();
    send(16'h5678); send(16'h5678); send(16'h5678);
    @(negedge clk);
    chk("t4_drain_cmp",   int'(cmp_state), 1);
    chk("t4_drain_ready", int'(in_ready),  0);
    chk("t4_drain_busy",  int'(busy),      1);
    sync(); sync();
    @(negedge clk);
    chk("t4_scan_cmp", int'(cmp_state), 3);
    sync();
    start = 1'b1; sync(); start = 1'b0;
    wait_frames("t4");
    repeat (8) @(posedge clk);
    chk("t4_busy_after", int'(busy), 0);
    sync();

    // start and abort together in IDLE
    start = 1'b1; abort = 1'b1; sync(); start = 1'b0; abort = 1'b0;
    @(negedge clk);
    chk("sa_busy", int'(busy), 0);
    sync();

    // 5: abort after two words, results of frame 4 must survive
    do_start(63);
    send(16'h1111); send(16'h1111);
    abort = 1'b1; sync(); abort = 1'b0;
    @(negedge clk);
    chk("t5_ready",      int'(in_ready),   0);
    chk("t5_busy",       int'(busy),       0);
    chk("t5_best_idx",   int'(best_idx),   3);
    chk("t5_best_score", int'(best_score), 20);
    chk("t5_match",      int'(match),      1);
    repeat (12) @(posedge clk);
    #1;
    s_q.push_back(exp_t'{2, 4, 1});
    do_start(4);
    for (int k = 0; k < 4; k++) send(16'h2133);
    wait_frames("t5");

    // 6: reset in DRAIN, then a clean frame and the full-size instance
    do_start(63);
    for (int k = 0; k < 4; k++) send(16'h1111);
    #2 rst = 1'b1;
    #1 chk_zero("t6_rst");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    sync();
    s_q.push_back(exp_t'{0, 4, 1});
    do_start(8);
    for (int k = 0; k < 4; k++) send(16'h4321);
    wait_frames("t6_small");

    b_q.push_back(exp_t'{0, 960, 1});
    b_start = 1'b1; b_thresh = B_ACC'(960);
    sync();
    b_start = 1'b0;
    b_in_valid = 1'b1; b_in_data = 16'hFFFF;
    begin
      int k = 0;
      for (int n = 0; n < 500 && k < BN; n++) begin
        @(negedge clk);
        if (b_in_ready) k++;
        sync();
      end
      b_in_valid = 1'b0;
      chk("t6_big_words", k, BN);
    end
    wait_frames("t6_big");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end
endmodule
